// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution unit: condition encodings,
// BHT counter states and the real-branch test.
package branch_pkg;

    localparam logic [2:0] BR_BLTZ = 3'b000;
    localparam logic [2:0] BR_BGEZ = 3'b001;
    localparam logic [2:0] BR_BEQ  = 3'b100;
    localparam logic [2:0] BR_BNE  = 3'b101;
    localparam logic [2:0] BR_BLEZ = 3'b110;
    localparam logic [2:0] BR_BGTZ = 3'b111;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Encodings 010 and 011 are the only non-branch ops.
    function automatic logic is_branch(input logic [2:0] br_op);
        return br_op[2] || !br_op[1];
    endfunction

endpackage

// File: rtl/branch_bht.sv
// Branch history table of 2-bit saturating counters with an asynchronous
// read port for fetch and one saturating update port for resolution.
module branch_bht
    import branch_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX     = $clog2(ENTRIES)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [IDX-1:0] rd_idx,
    output logic           rd_taken,
    input  logic           wr_en,
    input  logic [IDX-1:0] wr_idx,
    input  logic           wr_taken
);

    logic [1:0] ctr [ENTRIES];
    logic [1:0] wr_old;
    logic [1:0] wr_new;

    // Read sees the stored value, so a same-cycle update is not forwarded.
    assign rd_taken = ctr[rd_idx][1];
    assign wr_old   = ctr[wr_idx];

    always_comb begin
        wr_new = wr_old;
        if (wr_taken && wr_old != ST) begin
            wr_new = wr_old + 2'd1;
        end else if (!wr_taken && wr_old != SNT) begin
            wr_new = wr_old - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr[i] <= WNT;
            end
        end else if (wr_en) begin
            ctr[wr_idx] <= wr_new;
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// Resolves conditional branches on signed operands, registers the outcome,
// trains the BHT and counts mispredictions with saturation.
module branch_resolver
    import branch_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int PC_WIDTH    = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [PC_WIDTH-1:0]  Fetch_PC,
    output logic                 Predict_Taken,
    input  logic                 Valid_In,
    input  logic                 Stall,
    input  logic                 Flush,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [2:0]           BrOp,
    input  logic [PC_WIDTH-1:0]  Br_PC,
    input  logic                 Pred_Taken,
    output logic                 Valid_Out,
    output logic                 Take_Branch,
    output logic                 Mispredict,
    output logic [CNT_WIDTH-1:0] Mispredict_Count
);

    localparam int IDX = $clog2(BHT_ENTRIES);

    logic outcome;
    logic accept;
    logic mispredict_now;
    logic a_neg;
    logic a_zero;
    logic unused_pc_bits;

    // PCs are word aligned and only the index bits select a counter.
    assign unused_pc_bits = ^{Fetch_PC[PC_WIDTH-1:IDX+2], Fetch_PC[1:0],
                              Br_PC[PC_WIDTH-1:IDX+2], Br_PC[1:0]};

    assign a_neg  = A[WIDTH-1];
    assign a_zero = (A == '0);

    always_comb begin
        outcome = 1'b0;
        case (BrOp)
            BR_BEQ:  outcome = (A == B);
            BR_BNE:  outcome = (A != B);
            BR_BLEZ: outcome = a_neg || a_zero;
            BR_BGTZ: outcome = !a_neg && !a_zero;
            BR_BLTZ: outcome = a_neg;
            BR_BGEZ: outcome = !a_neg;
            default: outcome = 1'b0;
        endcase
    end

    assign accept         = Valid_In && !Stall && !Flush;
    assign mispredict_now = (outcome != Pred_Taken);

    branch_bht #(
        .ENTRIES (BHT_ENTRIES),
        .IDX     (IDX)
    ) u_bht (
        .clk      (Clk),
        .rst      (Rst),
        .rd_idx   (Fetch_PC[IDX+1:2]),
        .rd_taken (Predict_Taken),
        .wr_en    (accept && is_branch(BrOp)),
        .wr_idx   (Br_PC[IDX+1:2]),
        .wr_taken (outcome)
    );

    // Flush beats Stall; Take_Branch keeps the last resolved outcome when idle.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Valid_Out        <= 1'b0;
            Take_Branch      <= 1'b0;
            Mispredict       <= 1'b0;
            Mispredict_Count <= '0;
        end else if (Flush) begin
            Valid_Out  <= 1'b0;
            Mispredict <= 1'b0;
        end else if (!Stall) begin
            Valid_Out  <= Valid_In;
            Mispredict <= Valid_In && mispredict_now;
            if (Valid_In) begin
                Take_Branch <= outcome;
                if (mispredict_now && Mispredict_Count != '1) begin
                    Mispredict_Count <= Mispredict_Count + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed testbench for branch_resolver: conditions, BHT training, stall,
// flush, read-before-write, counter saturation and asynchronous reset.
module tb_branch_resolver;
    import branch_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        valid_in;
    logic        stall;
    logic        flush;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  br_op;
    logic [31:0] br_pc;
    logic        pred_taken;

    logic        predict_taken;
    logic        valid_out;
    logic        take_branch;
    logic        mispredict;
    logic [15:0] mispredict_count;

    logic        sat_predict_taken;
    logic        sat_valid_out;
    logic        sat_take_branch;
    logic        sat_mispredict;
    logic [1:0]  sat_mispredict_count;

    int tests;
    int failures;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        take;
    } vec_t;

    vec_t vecs [7];

    branch_resolver dut (
        .Clk              (clk),
        .Rst              (rst),
        .Fetch_PC         (fetch_pc),
        .Predict_Taken    (predict_taken),
        .Valid_In         (valid_in),
        .Stall            (stall),
        .Flush            (flush),
        .A                (a),
        .B                (b),
        .BrOp             (br_op),
        .Br_PC            (br_pc),
        .Pred_Taken       (pred_taken),
        .Valid_Out        (valid_out),
        .Take_Branch      (take_branch),
        .Mispredict       (mispredict),
        .Mispredict_Count (mispredict_count)
    );

    branch_resolver #(.CNT_WIDTH(2)) dut_sat (
        .Clk              (clk),
        .Rst              (rst),
        .Fetch_PC         (fetch_pc),
        .Predict_Taken    (sat_predict_taken),
        .Valid_In         (valid_in),
        .Stall            (stall),
        .Flush            (flush),
        .A                (a),
        .B                (b),
        .BrOp             (br_op),
        .Br_PC            (br_pc),
        .Pred_Taken       (pred_taken),
        .Valid_Out        (sat_valid_out),
        .Take_Branch      (sat_take_branch),
        .Mispredict       (sat_mispredict),
        .Mispredict_Count (sat_mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs, then returns 1 time unit after the edge.
    task automatic applyStimulus(input logic v, input logic s, input logic f,
                                 input logic [2:0] op, input logic [31:0] opa,
                                 input logic [31:0] opb, input logic [31:0] pc,
                                 input logic pt);
        valid_in   = v;
        stall      = s;
        flush      = f;
        br_op      = op;
        a          = opa;
        b          = opb;
        br_pc      = pc;
        pred_taken = pt;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic checkAllPredictZero(input string tag);
        for (int i = 0; i < 16; i++) begin
            fetch_pc = 32'(i * 4);
            #1;
            checkOutput(tag, {31'd0, predict_taken}, 32'd0);
        end
    endtask

    initial begin
        tests      = 0;
        failures   = 0;
        rst        = 1'b1;
        fetch_pc   = '0;
        valid_in   = 1'b0;
        stall      = 1'b0;
        flush      = 1'b0;
        a          = '0;
        b          = '0;
        br_op      = 3'b010;
        br_pc      = '0;
        pred_taken = 1'b0;

        vecs = '{'{BR_BNE,  32'd5,          32'd5, 1'b0},
                 '{BR_BLTZ, 32'hFFFF_FFFF,  32'd9, 1'b1},
                 '{BR_BLEZ, 32'hFFFF_FFFF,  32'd9, 1'b1},
                 '{BR_BGEZ, 32'hFFFF_FFFF,  32'd9, 1'b0},
                 '{BR_BGTZ, 32'hFFFF_FFFF,  32'd9, 1'b0},
                 '{BR_BLEZ, 32'd0,          32'd9, 1'b1},
                 '{BR_BGEZ, 32'd0,          32'd9, 1'b1}};

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", {31'd0, valid_out}, 32'd0);
        checkOutput("rst_take", {31'd0, take_branch}, 32'd0);
        checkOutput("rst_misp", {31'd0, mispredict}, 32'd0);
        checkOutput("rst_count", {16'd0, mispredict_count}, 32'd0);
        checkAllPredictZero("rst_predict");
        rst = 1'b0;

        // beq 5,5 taken, then an idle cycle holds Take_Branch
        applyStimulus(1, 0, 0, BR_BEQ, 32'd5, 32'd5, 32'h104, 0);
        checkOutput("beq_valid", {31'd0, valid_out}, 32'd1);
        checkOutput("beq_take", {31'd0, take_branch}, 32'd1);
        checkOutput("beq_misp", {31'd0, mispredict}, 32'd1);
        checkOutput("beq_count", {16'd0, mispredict_count}, 32'd1);
        applyStimulus(0, 0, 0, BR_BEQ, 32'd5, 32'd5, 32'h104, 0);
        checkOutput("idle_valid", {31'd0, valid_out}, 32'd0);
        checkOutput("idle_misp", {31'd0, mispredict}, 32'd0);
        checkOutput("idle_take_hold", {31'd0, take_branch}, 32'd1);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(1, 0, 0, vecs[i].op, vecs[i].a, vecs[i].b, 32'h104, 0);
            checkOutput($sformatf("cond%0d_valid", i), {31'd0, valid_out}, 32'd1);
            checkOutput($sformatf("cond%0d_take", i), {31'd0, take_branch},
                        {31'd0, vecs[i].take});
            checkOutput($sformatf("cond%0d_misp", i), {31'd0, mispredict},
                        {31'd0, vecs[i].take});
        end
        checkOutput("cond_count", {16'd0, mispredict_count}, 32'd5);
        checkOutput("sat_count5", {30'd0, sat_mispredict_count}, 32'd3);
        fetch_pc = 32'h104;
        #1;
        checkOutput("cond_bht_idx1", {31'd0, predict_taken}, 32'd1);

        // Non-branch op: never taken, mispredicts against Pred_Taken=1, no BHT update
        applyStimulus(1, 0, 0, 3'b010, 32'd7, 32'd7, 32'h108, 1);
        checkOutput("nop_take", {31'd0, take_branch}, 32'd0);
        checkOutput("nop_misp", {31'd0, mispredict}, 32'd1);
        checkOutput("nop_count", {16'd0, mispredict_count}, 32'd6);
        applyStimulus(1, 0, 0, BR_BEQ, 32'd1, 32'd1, 32'h108, 1);
        checkOutput("nop_follow_misp", {31'd0, mispredict}, 32'd0);
        fetch_pc = 32'h108;
        #1;
        checkOutput("nop_no_bht_update", {31'd0, predict_taken}, 32'd1);

        // Training at 0x40; same-cycle lookup sees the pre-update counter
        fetch_pc = 32'h40;
        for (int k = 0; k < 4; k++) begin
            valid_in   = 1'b1;
            br_op      = BR_BEQ;
            a          = 32'd1;
            b          = 32'd1;
            br_pc      = 32'h40;
            pred_taken = 1'b0;
            #1;
            checkOutput($sformatf("train%0d_pre", k), {31'd0, predict_taken},
                        (k == 0) ? 32'd0 : 32'd1);
            @(posedge clk);
            #1;
            valid_in = 1'b0;
            checkOutput($sformatf("train%0d_post", k), {31'd0, predict_taken}, 32'd1);
            checkOutput($sformatf("train%0d_misp", k), {31'd0, mispredict}, 32'd1);
        end
        checkOutput("train_count", {16'd0, mispredict_count}, 32'd10);

        // Stall holds outputs, counters and the BHT
        applyStimulus(1, 1, 0, BR_BEQ, 32'd2, 32'd2, 32'h10C, 1);
        checkOutput("stall_valid", {31'd0, valid_out}, 32'd1);
        checkOutput("stall_misp", {31'd0, mispredict}, 32'd1);
        checkOutput("stall_count", {16'd0, mispredict_count}, 32'd10);
        fetch_pc = 32'h10C;
        #1;
        checkOutput("stall_bht", {31'd0, predict_taken}, 32'd0);

        // Flush wins over Stall and Valid_In
        applyStimulus(1, 1, 1, BR_BEQ, 32'd2, 32'd2, 32'h10C, 0);
        checkOutput("flush_valid", {31'd0, valid_out}, 32'd0);
        checkOutput("flush_misp", {31'd0, mispredict}, 32'd0);
        checkOutput("flush_count", {16'd0, mispredict_count}, 32'd10);
        checkOutput("flush_bht", {31'd0, predict_taken}, 32'd0);

        // Asynchronous reset in the middle of a request
        applyStimulus(1, 0, 0, BR_BEQ, 32'd3, 32'd3, 32'h110, 0);
        checkOutput("pre_rst_count", {16'd0, mispredict_count}, 32'd11);
        valid_in = 1'b1;
        br_op    = BR_BEQ;
        br_pc    = 32'h40;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_valid", {31'd0, valid_out}, 32'd0);
        checkOutput("arst_take", {31'd0, take_branch}, 32'd0);
        checkOutput("arst_misp", {31'd0, mispredict}, 32'd0);
        checkOutput("arst_count", {16'd0, mispredict_count}, 32'd0);
        checkOutput("arst_sat_count", {30'd0, sat_mispredict_count}, 32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        valid_in = 1'b0;
        checkOutput("arst_drop_valid", {31'd0, valid_out}, 32'd0);
        checkAllPredictZero("arst_predict");

        applyStimulus(1, 0, 0, BR_BEQ, 32'd3, 32'd3, 32'h40, 0);
        checkOutput("post_rst_valid", {31'd0, valid_out}, 32'd1);
        checkOutput("post_rst_take", {31'd0, take_branch}, 32'd1);
        checkOutput("post_rst_count", {16'd0, mispredict_count}, 32'd1);
        fetch_pc = 32'h40;
        #1;
        checkOutput("post_rst_bht", {31'd0, predict_taken}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
